// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM state encoding and default sizing.
package pulse_meter_pkg;

  localparam int DEFAULT_CNT_W          = 24;
  localparam int DEFAULT_TIMEOUT_CYCLES = 10000000;
  localparam int DEFAULT_TIMEOUT_TURBO  = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Two-flop synchroniser followed by a registered rise/fall detector.
// Strobes appear three clocks after the asynchronous input edge.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic signal_in,
  output logic rise,
  output logic fall
);

  logic sync_1, sync_2, sync_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1    <= RESET_VAL;
      sync_2    <= RESET_VAL;
      sync_prev <= RESET_VAL;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_1    <= signal_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      rise      <= sync_2 & ~sync_prev;
      fall      <= ~sync_2 & sync_prev;
    end
  end

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and period of an asynchronous pulse train, publishing
// back-to-back results with a sticky no-signal timeout.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_TURBO  = DEFAULT_TIMEOUT_TURBO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             turbosim,
  input  logic             signal_in,
  input  logic             enable,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  output logic [7:0]       meas_count,
  output logic             no_signal,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] LIMIT_NORMAL = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT_TURBO  = CNT_W'(TIMEOUT_TURBO - 1);

  state_t state, next_state;

  logic             rise, fall;
  logic [CNT_W-1:0] period_cnt, high_cnt, high_cap, timeout_cnt;
  logic [CNT_W-1:0] timeout_limit;
  logic             timeout_hit;
  logic             start_meas, capture_high, publish, enter_arm, set_no_signal;

  // Counters restart at 0 on the starting strobe, so the distance between
  // strobes is the counter value plus one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_edge #(
    .RESET_VAL(1'b0)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .signal_in(signal_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign timeout_limit = turbosim ? LIMIT_TURBO : LIMIT_NORMAL;
  assign timeout_hit   = (state != IDLE) && (timeout_cnt >= timeout_limit);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    start_meas    = 1'b0;
    capture_high  = 1'b0;
    publish       = 1'b0;
    enter_arm     = 1'b0;
    set_no_signal = 1'b0;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          next_state = ARM;
          enter_arm  = 1'b1;
        end
        ARM: begin
          if (rise) begin
            next_state = HIGH;
            start_meas = 1'b1;
          end else if (timeout_hit) begin
            enter_arm     = 1'b1;
            set_no_signal = 1'b1;
          end
        end
        HIGH: begin
          // A rise without a preceding fall means the fall was lost: restart.
          if (rise) begin
            start_meas = 1'b1;
          end else if (fall) begin
            next_state   = LOW;
            capture_high = 1'b1;
          end else if (timeout_hit) begin
            next_state    = ARM;
            enter_arm     = 1'b1;
            set_no_signal = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            next_state = HIGH;
            publish    = 1'b1;
            start_meas = 1'b1;
          end else if (timeout_hit) begin
            next_state    = ARM;
            enter_arm     = 1'b1;
            set_no_signal = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      period_cnt  <= '0;
      high_cnt    <= '0;
      high_cap    <= '0;
      timeout_cnt <= '0;
      meas_high   <= '0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
      meas_count  <= 8'd0;
      no_signal   <= 1'b0;
    end else begin
      if (enter_arm || rise || fall)
        timeout_cnt <= '0;
      else if (state != IDLE && timeout_cnt != CNT_MAX)
        timeout_cnt <= timeout_cnt + 1'b1;

      if (start_meas) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (state != IDLE) begin
        period_cnt <= sat_inc(period_cnt);
        if (state == HIGH) high_cnt <= sat_inc(high_cnt);
      end

      if (capture_high) high_cap <= sat_inc(high_cnt);

      meas_valid <= publish;
      if (publish) begin
        meas_period <= sat_inc(period_cnt);
        meas_high   <= high_cap;
        meas_count  <= meas_count + 8'd1;
      end

      if (publish)            no_signal <= 1'b0;
      else if (set_no_signal) no_signal <= 1'b1;
    end
  end

endmodule
